// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter slice.
// No logic; constants and state encoding only.
// Backpressure: n/a.
package uart_pkg;

    localparam int FRAME_W     = 8;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_TIMEOUT = 4;

    typedef logic [FRAME_W-1:0] frame_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Per-channel byte FIFO in front of the transmit arbiter.
// Latency: a pushed byte is visible on dout/empty one cycle after the push edge.
// Backpressure: push is ignored while full, pop is ignored while empty.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic   baudclk,
    input  logic   reset,
    input  logic   push,
    input  logic   pop,
    input  frame_t din,
    output frame_t dout,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    frame_t      mem [DEPTH];

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge baudclk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge baudclk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART sender between two byte FIFOs, one frame at a time.
// Latency: push at edge n -> tx_en/tx_data at edge n+1 when idle and the sender is free.
// Backpressure: req_ready drops when a FIFO is full; the sequencer waits on tx_status.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic         baudclk,
    input  logic         reset,
    input  logic [1:0]   req_valid,
    input  logic [7:0]   req_data0,
    input  logic [7:0]   req_data1,
    output logic [1:0]   req_ready,
    output logic [7:0]   tx_data,
    output logic         tx_en,
    input  logic         tx_status,
    output logic         busy,
    output logic         err_timeout,
    input  logic         err_clr,
    output logic [15:0]  sent_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);

    tx_state_t   state;
    tx_state_t   state_nxt;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;
    logic        last_grant;
    logic        grant;
    logic [1:0]  pop;
    logic [1:0]  full;
    logic [1:0]  empty;
    frame_t      dout0;
    frame_t      dout1;
    logic        timeout_hit;
    logic        frame_done;
    logic [15:0] sent_cnt_q;

    uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo0 (
        .baudclk (baudclk),
        .reset   (reset),
        .push    (req_valid[0] && !full[0]),
        .pop     (pop[0]),
        .din     (req_data0),
        .dout    (dout0),
        .full    (full[0]),
        .empty   (empty[0])
    );

    uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo1 (
        .baudclk (baudclk),
        .reset   (reset),
        .push    (req_valid[1] && !full[1]),
        .pop     (pop[1]),
        .din     (req_data1),
        .dout    (dout1),
        .full    (full[1]),
        .empty   (empty[1])
    );

    assign req_ready = ~full;
    assign busy      = (state != ST_IDLE) || !(&empty);
    assign sent_cnt  = sent_cnt_q;

    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        grant       = last_grant;
        pop         = 2'b00;
        timeout_hit = 1'b0;
        frame_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!(&empty) && tx_status) begin
                    // With both channels waiting, the one not served last goes next.
                    if (!empty[0] && !empty[1]) begin
                        grant = ~last_grant;
                    end else begin
                        grant = empty[0];
                    end
                    pop       = grant ? 2'b10 : 2'b01;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                timer_nxt = '0;
                state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!tx_status) begin
                    state_nxt = ST_WAIT_DONE;
                end else begin
                    timer_nxt = timer + 1'b1;
                    if (timer_nxt == TW'(TIMEOUT)) begin
                        timeout_hit = 1'b1;
                        state_nxt   = ST_IDLE;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (tx_status) begin
                    frame_done = 1'b1;
                    state_nxt  = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge baudclk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    always_ff @(posedge baudclk or negedge reset) begin
        if (!reset) begin
            tx_en       <= 1'b0;
            tx_data     <= '0;
            last_grant  <= 1'b1;
            err_timeout <= 1'b0;
            sent_cnt_q  <= '0;
        end else begin
            tx_en <= (state_nxt == ST_LOAD);
            if (|pop) begin
                tx_data    <= grant ? dout1 : dout0;
                last_grant <= grant;
            end
            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end else if (err_clr) begin
                err_timeout <= 1'b0;
            end
            if (frame_done) begin
                sent_cnt_q <= sent_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a queue-based frame model and a sender model.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 4;

    logic        baudclk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [7:0]  req_data0;
    logic [7:0]  req_data1;
    logic [1:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        tx_status;
    logic        busy;
    logic        err_timeout;
    logic        err_clr;
    logic [15:0] sent_cnt;

    uart_tx_arbiter #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .baudclk     (baudclk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data0   (req_data0),
        .req_data1   (req_data1),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_en       (tx_en),
        .tx_status   (tx_status),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_clr     (err_clr),
        .sent_cnt    (sent_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        baudclk = 1'b0;
        forever #5 baudclk = ~baudclk;
    end

    // Sender: 0 = normal frame timing, 1 = never goes busy, 2 = held busy.
    int mode   = 0;
    int st_cnt = 0;
    initial begin
        tx_status = 1'b1;
        forever begin
            @(posedge baudclk);
            #1;
            if (!reset) begin
                st_cnt    = 0;
                tx_status = 1'b1;
            end else if (mode == 2) begin
                st_cnt    = 0;
                tx_status = 1'b0;
            end else if (mode == 1) begin
                st_cnt    = 0;
                tx_status = 1'b1;
            end else if (st_cnt == 0) begin
                tx_status = 1'b1;
                if (tx_en) st_cnt = 1;
            end else begin
                st_cnt++;
                if (st_cnt == 3) begin
                    tx_status = 1'b0;
                end else if (st_cnt == 14) begin
                    tx_status = 1'b1;
                    st_cnt    = 0;
                end
            end
        end
    end

    // Frame-level model: byte queues, round-robin pointer, and the age of the open frame.
    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    logic [7:0]  sent_log[$];
    bit          m_lg;
    bit          m_frame;
    bit          m_low;
    int          m_age;
    bit          m_err;
    bit          m_txen;
    logic [7:0]  m_data;
    logic [15:0] m_cnt;
    logic [1:0]  p_valid;
    logic [7:0]  p_d0;
    logic [7:0]  p_d1;
    logic        p_status;
    logic        p_clr;
    bit          p_rst_low = 1'b1;
    int          preload_evt  = 0;
    int          preload_seen = 0;

    function automatic void m_reset();
        q0.delete();
        q1.delete();
        m_lg    = 1'b1;
        m_frame = 1'b0;
        m_low   = 1'b0;
        m_age   = 0;
        m_err   = 1'b0;
        m_txen  = 1'b0;
        m_data  = 8'h00;
        m_cnt   = 16'h0000;
    endfunction

    function automatic void m_step();
        bit acc0;
        bit acc1;
        bit set_err;
        bit w;
        acc0    = p_valid[0] && (q0.size() < DEPTH);
        acc1    = p_valid[1] && (q1.size() < DEPTH);
        set_err = 1'b0;
        m_txen  = 1'b0;
        if (!m_frame) begin
            if ((q0.size() > 0 || q1.size() > 0) && p_status) begin
                if (q0.size() > 0 && q1.size() > 0) w = !m_lg;
                else w = (q0.size() == 0);
                m_data  = w ? q1.pop_front() : q0.pop_front();
                m_lg    = w;
                m_frame = 1'b1;
                m_low   = 1'b0;
                m_age   = 0;
                m_txen  = 1'b1;
            end
        end else begin
            m_age++;
            if (m_age >= 2) begin
                if (!m_low) begin
                    if (!p_status) begin
                        m_low = 1'b1;
                    end else if (m_age - 1 == TIMEOUT) begin
                        set_err = 1'b1;
                        m_frame = 1'b0;
                    end
                end else if (p_status) begin
                    m_cnt   = m_cnt + 16'd1;
                    m_frame = 1'b0;
                end
            end
        end
        if (set_err) m_err = 1'b1;
        else if (p_clr) m_err = 1'b0;
        if (acc0) q0.push_back(p_d0);
        if (acc1) q1.push_back(p_d1);
    endfunction

    always @(negedge baudclk) begin
        if (!reset || p_rst_low) m_reset();
        else m_step();
        if (preload_evt != preload_seen) begin
            m_cnt        = 16'hFFFF;
            preload_seen = preload_evt;
        end
        chk("req_ready",   req_ready,   {q1.size() < DEPTH, q0.size() < DEPTH});
        chk("tx_en",       tx_en,       m_txen);
        chk("tx_data",     tx_data,     m_data);
        chk("busy",        busy,        m_frame || q0.size() > 0 || q1.size() > 0);
        chk("err_timeout", err_timeout, m_err);
        chk("sent_cnt",    sent_cnt,    m_cnt);
        if (reset && tx_en) sent_log.push_back(tx_data);
        p_valid   = req_valid;
        p_d0      = req_data0;
        p_d1      = req_data1;
        p_status  = tx_status;
        p_clr     = err_clr;
        p_rst_low = !reset;
    end

    task automatic tick();
        @(posedge baudclk);
        #1;
    endtask

    task automatic push(input logic [1:0] ch, input logic [7:0] d0, input logic [7:0] d1);
        req_valid = ch;
        req_data0 = d0;
        req_data1 = d1;
        tick();
        req_valid = 2'b00;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        chk(name, busy, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        int pulses;
        reset     = 1'b0;
        req_valid = 2'b00;
        req_data0 = 8'h00;
        req_data1 = 8'h00;
        err_clr   = 1'b0;
        tick();
        tick();
        chk("rst_ready",   req_ready,   2'b11);
        chk("rst_tx_data", tx_data,     8'h00);
        chk("rst_tx_en",   tx_en,       1'b0);
        chk("rst_busy",    busy,        1'b0);
        chk("rst_err",     err_timeout, 1'b0);
        chk("rst_cnt",     sent_cnt,    16'h0000);
        reset = 1'b1;
        tick();

        // Single byte: tx_en one cycle after the push edge, then a full frame.
        base = sent_log.size();
        push(2'b01, 8'hA5, 8'h00);
        tick();
        chk("single_txen_hi", tx_en, 1'b1);
        chk("single_data",    tx_data, 8'hA5);
        tick();
        chk("single_txen_lo", tx_en, 1'b0);
        wait_idle("single_idle", 200);
        chk("single_cnt",     sent_cnt, 16'd1);
        chk("single_nlog",    sent_log.size() - base, 1);
        if (sent_log.size() > base) chk("single_log", sent_log[base], 8'hA5);

        // Round-robin from a fresh last_grant.
        do_reset();
        base      = sent_log.size();
        req_valid = 2'b11;
        req_data0 = 8'h01;
        req_data1 = 8'h11;
        tick();
        req_data0 = 8'h02;
        req_data1 = 8'h12;
        tick();
        req_valid = 2'b00;
        wait_idle("rr_idle", 400);
        chk("rr_nlog", sent_log.size() - base, 4);
        if (sent_log.size() >= base + 4) begin
            chk("rr_0", sent_log[base],     8'h01);
            chk("rr_1", sent_log[base + 1], 8'h11);
            chk("rr_2", sent_log[base + 2], 8'h02);
            chk("rr_3", sent_log[base + 3], 8'h12);
        end
        chk("rr_cnt", sent_cnt, 16'd4);

        // Full FIFO on ch1 while the sender is held busy.
        mode = 2;
        tick();
        tick();
        base = sent_log.size();
        req_valid = 2'b10;
        for (int i = 0; i < 4; i++) begin
            req_data1 = 8'h21 + 8'(i);
            tick();
        end
        chk("full_ready_after4", req_ready[1], 1'b0);
        req_data1 = 8'h25;
        tick();
        req_valid = 2'b00;
        chk("full_ready_after5", req_ready[1], 1'b0);
        mode = 0;
        wait_idle("full_idle", 600);
        chk("full_nlog", sent_log.size() - base, 4);
        if (sent_log.size() >= base + 4) begin
            chk("full_0", sent_log[base],     8'h21);
            chk("full_3", sent_log[base + 3], 8'h24);
        end
        chk("full_cnt", sent_cnt, 16'd8);

        // Timeout: sender never reports busy.
        mode = 1;
        push(2'b01, 8'hA7, 8'h00);
        n = 0;
        while (!tx_en && n < 20) begin
            tick();
            n++;
        end
        chk("to_txen_seen", tx_en, 1'b1);
        repeat (4) tick();
        chk("to_err_early", err_timeout, 1'b0);
        tick();
        chk("to_err_set", err_timeout, 1'b1);
        chk("to_busy",    busy,        1'b0);
        chk("to_cnt",     sent_cnt,    16'd8);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("to_err_clr", err_timeout, 1'b0);
        mode = 0;
        tick();

        // Reset mid-frame with two bytes queued.
        push(2'b01, 8'hB1, 8'h00);
        push(2'b11, 8'hB2, 8'hC2);
        n = 0;
        while (tx_status && n < 30) begin
            tick();
            n++;
        end
        chk("mid_status_low", tx_status, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("mid_ready", req_ready,   2'b11);
        chk("mid_data",  tx_data,     8'h00);
        chk("mid_txen",  tx_en,       1'b0);
        chk("mid_busy",  busy,        1'b0);
        chk("mid_err",   err_timeout, 1'b0);
        chk("mid_cnt",   sent_cnt,    16'h0000);
        tick();
        tick();
        reset  = 1'b1;
        pulses = 0;
        repeat (40) begin
            tick();
            if (tx_en) pulses++;
        end
        chk("mid_no_txen", pulses, 0);

        // Counter wrap.
        force dut.sent_cnt_q = 16'hFFFF;
        preload_evt++;
        tick();
        release dut.sent_cnt_q;
        base = sent_log.size();
        push(2'b01, 8'hD4, 8'h00);
        wait_idle("wrap_idle", 200);
        chk("wrap_cnt", sent_cnt, 16'h0000);
        if (sent_log.size() > base) chk("wrap_log", sent_log[base], 8'hD4);
        else chk("wrap_nlog", sent_log.size() - base, 1);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmit sender between two byte requesters, channel 0 (CPU peripheral bus) and channel 1 (receive-echo / debug path). Each channel has its own small FIFO. A round-robin arbiter picks the next byte, and a sequencer drives the sender's `TX_DATA`/`TX_EN` pair and tracks `TX_STATUS` through one complete frame before it issues the next. The block sits in the Peripheral tree between the requesters and `UART_Sender`, in the baudclk domain.

## Interface
- `DEPTH`, 4: entries per channel FIFO; must be a power of 2, at least 2.
- `TIMEOUT`, 4: baudclk cycles allowed for `tx_status` to fall after a `tx_en` pulse.
- `baudclk`  in  1: clock; every register in the block is on its rising edge.
- `reset`  in  1: reset, asynchronous, active-low.
- `req_valid[1:0]`  in  2: per-channel push request; requesters are already synchronous to baudclk.
- `req_data0`, `req_data1`  in  8 each: per-channel byte.
- `req_ready[1:0]`  out  2: per-channel "FIFO not full".
- `tx_data`  out  8: byte to the sender's `TX_DATA`.
- `tx_en`  out  1: load pulse to the sender's `TX_EN`.
- `tx_status`  in  1: sender `TX_STATUS`; 1 = free, 0 = sending.
- `busy`  out  1: 1 while any FIFO holds data or the FSM is not in IDLE.
- `err_timeout`  out  1: sticky flag, set by a dropped byte.
- `err_clr`  in  1: clears `err_timeout`.
- `sent_cnt`  out  16: count of completed frames; wraps at 16'hFFFF.

## Operation
- Reset values: `req_ready`=2'b11, `tx_data`=8'h00, `tx_en`=0, `busy`=0, `err_timeout`=0, `sent_cnt`=0, FIFOs empty, FSM in IDLE, `last_grant`=1.
- Push rule: a byte is written when `req_valid[i]` and `req_ready[i]` are both 1 at a clock edge. `req_ready[i]` = !full[i] and depends on the registered count only. A push to a full FIFO is therefore refused, even if a pop happens in the same cycle.
- Arbitration, in IDLE only:
  - One channel non-empty: that channel wins.
  - Both non-empty: the channel other than `last_grant` wins.
  - The winner is popped, its byte is registered into `tx_data`, and `last_grant` takes the winner's value.
- FSM states:
  - IDLE: if any channel is non-empty and `tx_status`=1, pop and go to LOAD. Otherwise stay.
  - LOAD: `tx_en`=1 for exactly this one cycle; go to WAIT_BUSY and clear the timer.
  - WAIT_BUSY: if `tx_status`=0, go to WAIT_DONE. Otherwise increment the timer. When the timer reaches `TIMEOUT`, set `err_timeout`, go to IDLE, and drop the byte (`sent_cnt` unchanged).
  - WAIT_DONE: when `tx_status`=1, increment `sent_cnt` and go to IDLE.
- `tx_data` is held constant from LOAD through WAIT_DONE. It changes only on a pop.
- `tx_en` is a registered output. It is never high for two consecutive cycles, and it is never high outside LOAD.
- `err_clr` and a new timeout in the same cycle: set wins.
- `sent_cnt` wraps from 16'hFFFF to 0 with no flag.
- Reset mid-frame: the whole block returns to reset values and queued bytes are lost. The sender shares the reset net, so it also returns to free.

## Timing
- Push into empty FIFOs with the FSM in IDLE and `tx_status`=1 (push at edge n):
  - FIFO is non-empty after edge n.
  - IDLE→LOAD at edge n+1, with `tx_data` valid.
  - `tx_en` high from edge n+1 to edge n+2.
- The sender drops `tx_status` within 2 edges after `tx_en` falls. `TIMEOUT`=4 gives margin.
- Back-to-back frames: the next `tx_en` rises no earlier than 2 edges after `tx_status` is sampled high in WAIT_DONE (WAIT_DONE→IDLE→LOAD).
- Pop happens on the IDLE→LOAD edge only, so at most one pop per frame.
- `busy` is combinational from FSM state and FIFO empties; all other outputs are registered.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
  - Frame-width constant (8).
  - Default `DEPTH`/`TIMEOUT`.
- Sub-module `uart_tx_fifo`, instantiated twice:
  - Synchronous FIFO, parameter `DEPTH`, ptr width = log2(`DEPTH`)+1.
  - Ports: push, pop, data in, data out, full, empty.
  - Async active-low reset.
- The arbiter and FSM live in the top module.

## Test plan
- Single byte: push 8'hA5 on ch0; the bench sender model drops status 2 cycles after `tx_en` and raises it 11 cycles later → one `tx_en` pulse with `tx_data`=8'hA5, `sent_cnt`=1, `busy`=0 afterwards.
- Round-robin: fill ch0 with 8'h01 and 8'h02, and ch1 with 8'h11 and 8'h12, in the same cycles → transmit order 8'h01, 8'h11, 8'h02, 8'h12; `sent_cnt`=4.
- Full FIFO: push 5 bytes to ch1 while the FSM is held off by `tx_status`=0 → `req_ready[1]`=0 after the 4th push, the 5th byte is refused, and only 4 frames are later sent.
- Timeout: hold `tx_status`=1 after `tx_en` → `err_timeout`=1 after 4 cycles in WAIT_BUSY, FSM in IDLE, `sent_cnt` unchanged. Then pulse `err_clr` → 0.
- Reset mid-frame: assert reset during WAIT_DONE with 2 bytes queued → all outputs return to reset values immediately, and no `tx_en` pulse follows the release of reset.
- Wrap: preload `sent_cnt`=16'hFFFF via force and complete one frame → `sent_cnt`=0.
